// File: rtl/prt_pkg.sv
// Shared types and sizing for the packet reference table.
// Slot/byte-count types, the read-entry layout and the flat RAM address helper.
package prt_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int MEM_DEPTH  = 1518;
    localparam int NUM_SLOTS  = 10;

    localparam int SW        = $clog2(NUM_SLOTS);
    localparam int CW        = $clog2(MEM_DEPTH + 1);
    localparam int RAM_WORDS = NUM_SLOTS * MEM_DEPTH;
    localparam int AW        = $clog2(RAM_WORDS);

    typedef logic [SW-1:0] slot_t;
    typedef logic [CW-1:0] cnt_t;
    typedef logic [AW-1:0] addr_t;

    typedef struct packed {
        logic                  last;
        logic [DATA_WIDTH-1:0] data;
    } rd_entry_t;

    // Slots are laid out back to back in one flat RAM.
    function automatic addr_t ram_addr(slot_t s, cnt_t i);
        return addr_t'(s) * addr_t'(MEM_DEPTH) + addr_t'(i);
    endfunction

endpackage

// File: rtl/prt_mem.sv
// Simple dual-port RAM: one write port, one registered read port with enable.
// Only the output register is reset; stored contents survive reset.
module prt_mem #(
    parameter int DW    = 8,
    parameter int WORDS = 16,
    parameter int AW    = 4
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [WORDS];
    logic [DW-1:0] rdata_q;
    logic [DW-1:0] rdata_d;

    always_ff @(posedge CLK) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read-before-write on a same-address collision.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[raddr];
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/prt.sv
// Packet reference table: slot allocation, byte streaming in/out, slot release.
// state    | meaning
// W_IDLE   | no slot open for writing
// W_ACTIVE | slot wslot_q being filled, wcnt_q bytes so far
// R_IDLE   | no read in progress
// R_ACTIVE | streaming slot rslot_q, rcnt_q bytes delivered so far
module prt
    import prt_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  EN_start_writing_prt_entry,
    output logic                  RDY_start_writing_prt_entry,
    output logic [SW-1:0]         start_writing_prt_entry,
    input  logic                  EN_write_prt_entry,
    output logic                  RDY_write_prt_entry,
    input  logic [DATA_WIDTH-1:0] write_prt_entry_data,
    input  logic                  EN_finish_writing_prt_entry,
    output logic                  RDY_finish_writing_prt_entry,
    input  logic                  EN_invalidate_prt_entry,
    output logic                  RDY_invalidate_prt_entry,
    input  logic [SW-1:0]         invalidate_prt_entry_slot,
    input  logic                  EN_start_reading_prt_entry,
    output logic                  RDY_start_reading_prt_entry,
    input  logic [SW-1:0]         start_reading_prt_entry_slot,
    input  logic                  EN_read_prt_entry,
    output logic                  RDY_read_prt_entry,
    output logic [DATA_WIDTH:0]   read_prt_entry,
    output logic                  is_prt_slot_free,
    output logic                  RDY_is_prt_slot_free
);

    typedef enum logic {W_IDLE, W_ACTIVE} wstate_t;
    typedef enum logic {R_IDLE, R_ACTIVE} rstate_t;

    localparam logic [SW:0] SLOT_LIM  = (SW + 1)'(NUM_SLOTS);
    localparam cnt_t        DEPTH_CNT = cnt_t'(MEM_DEPTH);

    wstate_t wstate_q, wstate_d;
    slot_t   wslot_q, wslot_d;
    cnt_t    wcnt_q, wcnt_d;
    slot_t   alloc_q, alloc_d;
    logic [NUM_SLOTS-1:0] valid_q, valid_d;
    cnt_t    len_q [NUM_SLOTS];
    cnt_t    len_d [NUM_SLOTS];
    rstate_t rstate_q, rstate_d;
    slot_t   rslot_q, rslot_d;
    cnt_t    rcnt_q, rcnt_d;
    cnt_t    rlen_q, rlen_d;
    logic    last_q, last_d;
    logic    zero_q, zero_d;

    logic [NUM_SLOTS-1:0]  free_vec;
    slot_t                 free_idx;
    logic                  writing, reading;
    logic                  acc_start_w, acc_write, acc_finish, acc_inv, acc_start_r, acc_read;
    logic                  inv_in_range, rd_in_range, rd_last;
    logic [DATA_WIDTH-1:0] ram_rdata;
    rd_entry_t             rd_out;

    assign writing = (wstate_q == W_ACTIVE);
    assign reading = (rstate_q == R_ACTIVE);

    // The slot under construction is not valid yet but is not free either.
    always_comb begin
        free_vec = '0;
        free_idx = '0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            free_vec[s] = !valid_q[s] && !(writing && (wslot_q == slot_t'(s)));
        end
        for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
            if (free_vec[s]) begin
                free_idx = slot_t'(s);
            end
        end
    end

    assign is_prt_slot_free             = |free_vec;
    assign RDY_is_prt_slot_free         = 1'b1;
    assign RDY_invalidate_prt_entry     = 1'b1;
    assign RDY_start_writing_prt_entry  = is_prt_slot_free && !writing;
    assign RDY_write_prt_entry          = writing && (wcnt_q < DEPTH_CNT);
    assign RDY_finish_writing_prt_entry = writing;
    assign RDY_start_reading_prt_entry  = !reading;
    assign RDY_read_prt_entry           = reading;

    assign acc_start_w = EN_start_writing_prt_entry && RDY_start_writing_prt_entry;
    assign acc_write   = EN_write_prt_entry && RDY_write_prt_entry;
    assign acc_finish  = EN_finish_writing_prt_entry && RDY_finish_writing_prt_entry;
    assign acc_inv     = EN_invalidate_prt_entry && RDY_invalidate_prt_entry;
    assign acc_start_r = EN_start_reading_prt_entry && RDY_start_reading_prt_entry;
    assign acc_read    = EN_read_prt_entry && RDY_read_prt_entry;

    assign inv_in_range = {1'b0, invalidate_prt_entry_slot} < SLOT_LIM;
    assign rd_in_range  = {1'b0, start_reading_prt_entry_slot} < SLOT_LIM;
    assign rd_last      = (rlen_q == '0) || (rcnt_q == rlen_q - 1'b1);

    always_comb begin
        wstate_d = wstate_q;
        wslot_d  = wslot_q;
        wcnt_d   = wcnt_q;
        alloc_d  = alloc_q;
        valid_d  = valid_q;
        len_d    = len_q;
        case (wstate_q)
            W_IDLE: begin
                if (acc_start_w) begin
                    wstate_d = W_ACTIVE;
                    wslot_d  = free_idx;
                    alloc_d  = free_idx;
                    wcnt_d   = '0;
                end
            end
            W_ACTIVE: begin
                if (acc_write) begin
                    wcnt_d = wcnt_q + 1'b1;
                end
                if (acc_finish) begin
                    valid_d[wslot_q] = 1'b1;
                    len_d[wslot_q]   = wcnt_d;
                    wstate_d         = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
        if (acc_inv && inv_in_range && !(writing && (invalidate_prt_entry_slot == wslot_q))) begin
            valid_d[invalidate_prt_entry_slot] = 1'b0;
        end
    end

    // The length is latched at read start so a later rewrite of the slot cannot move the end.
    always_comb begin
        rstate_d = rstate_q;
        rslot_d  = rslot_q;
        rcnt_d   = rcnt_q;
        rlen_d   = rlen_q;
        last_d   = last_q;
        zero_d   = zero_q;
        case (rstate_q)
            R_IDLE: begin
                if (acc_start_r && rd_in_range && valid_q[start_reading_prt_entry_slot]) begin
                    rstate_d = R_ACTIVE;
                    rslot_d  = start_reading_prt_entry_slot;
                    rcnt_d   = '0;
                    rlen_d   = len_q[start_reading_prt_entry_slot];
                end
            end
            R_ACTIVE: begin
                if (acc_read) begin
                    last_d = rd_last;
                    zero_d = (rlen_q == '0);
                    rcnt_d = rcnt_q + 1'b1;
                    if (rd_last) begin
                        rstate_d = R_IDLE;
                    end
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wstate_q <= W_IDLE;
            wslot_q  <= '0;
            wcnt_q   <= '0;
            alloc_q  <= '0;
            valid_q  <= '0;
            for (int s = 0; s < NUM_SLOTS; s++) begin
                len_q[s] <= '0;
            end
            rstate_q <= R_IDLE;
            rslot_q  <= '0;
            rcnt_q   <= '0;
            rlen_q   <= '0;
            last_q   <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            wstate_q <= wstate_d;
            wslot_q  <= wslot_d;
            wcnt_q   <= wcnt_d;
            alloc_q  <= alloc_d;
            valid_q  <= valid_d;
            len_q    <= len_d;
            rstate_q <= rstate_d;
            rslot_q  <= rslot_d;
            rcnt_q   <= rcnt_d;
            rlen_q   <= rlen_d;
            last_q   <= last_d;
            zero_q   <= zero_d;
        end
    end

    prt_mem #(
        .DW    (DATA_WIDTH),
        .WORDS (RAM_WORDS),
        .AW    (AW)
    ) u_mem (
        .CLK   (CLK),
        .RST_N (RST_N),
        .we    (acc_write),
        .waddr (ram_addr(wslot_q, wcnt_q)),
        .wdata (write_prt_entry_data),
        .re    (acc_read),
        .raddr (ram_addr(rslot_q, rcnt_q)),
        .rdata (ram_rdata)
    );

    // An empty slot reads back as a single zero byte flagged last.
    assign rd_out.last             = last_q;
    assign rd_out.data             = zero_q ? '0 : ram_rdata;
    assign read_prt_entry          = rd_out;
    assign start_writing_prt_entry = alloc_q;

endmodule

// File: tb/tb_prt.sv
// Scoreboard bench for prt: a slot-level reference model predicts handshakes and read bytes.
module tb_prt;

    localparam int NS    = 10;
    localparam int DEPTH = 1518;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       EN_start_writing_prt_entry, EN_write_prt_entry, EN_finish_writing_prt_entry;
    logic       EN_invalidate_prt_entry, EN_start_reading_prt_entry, EN_read_prt_entry;
    logic [7:0] write_prt_entry_data;
    logic [3:0] invalidate_prt_entry_slot, start_reading_prt_entry_slot;
    logic       RDY_start_writing_prt_entry, RDY_write_prt_entry, RDY_finish_writing_prt_entry;
    logic       RDY_invalidate_prt_entry, RDY_start_reading_prt_entry, RDY_read_prt_entry;
    logic       is_prt_slot_free, RDY_is_prt_slot_free;
    logic [3:0] start_writing_prt_entry;
    logic [8:0] read_prt_entry;

    prt dut (
        .CLK                          (CLK),
        .RST_N                        (RST_N),
        .EN_start_writing_prt_entry   (EN_start_writing_prt_entry),
        .RDY_start_writing_prt_entry  (RDY_start_writing_prt_entry),
        .start_writing_prt_entry      (start_writing_prt_entry),
        .EN_write_prt_entry           (EN_write_prt_entry),
        .RDY_write_prt_entry          (RDY_write_prt_entry),
        .write_prt_entry_data         (write_prt_entry_data),
        .EN_finish_writing_prt_entry  (EN_finish_writing_prt_entry),
        .RDY_finish_writing_prt_entry (RDY_finish_writing_prt_entry),
        .EN_invalidate_prt_entry      (EN_invalidate_prt_entry),
        .RDY_invalidate_prt_entry     (RDY_invalidate_prt_entry),
        .invalidate_prt_entry_slot    (invalidate_prt_entry_slot),
        .EN_start_reading_prt_entry   (EN_start_reading_prt_entry),
        .RDY_start_reading_prt_entry  (RDY_start_reading_prt_entry),
        .start_reading_prt_entry_slot (start_reading_prt_entry_slot),
        .EN_read_prt_entry            (EN_read_prt_entry),
        .RDY_read_prt_entry           (RDY_read_prt_entry),
        .read_prt_entry               (read_prt_entry),
        .is_prt_slot_free             (is_prt_slot_free),
        .RDY_is_prt_slot_free         (RDY_is_prt_slot_free)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference model: what a packet table holds, not how the RTL holds it.
    logic [7:0] m_mem [NS][DEPTH];
    bit         m_valid [NS];
    int         m_len [NS];
    bit         m_wr, m_rd;
    int         m_wslot, m_wcnt, m_rslot, m_rcnt, m_rlen, m_alloc;
    logic [8:0] m_out;
    logic [8:0] exp_q [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int m_first_free();
        for (int i = 0; i < NS; i++) begin
            if (!m_valid[i] && !(m_wr && m_wslot == i)) return i;
        end
        return -1;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NS; i++) begin
            m_valid[i] = 0;
            m_len[i]   = 0;
        end
        m_wr = 0; m_rd = 0; m_wslot = 0; m_wcnt = 0;
        m_rslot = 0; m_rcnt = 0; m_rlen = 0; m_alloc = 0; m_out = '0;
        exp_q.delete();
    endtask

    // Monitor: every accepted read produces one output word on the following cycle.
    logic hs;
    always @(posedge CLK) begin
        hs = EN_read_prt_entry && RDY_read_prt_entry && RST_N;
        #1;
        if (hs) begin
            if (exp_q.size() == 0) begin
                chk("rd_unexpected", 32'(read_prt_entry), 32'h1ff);
            end else begin
                chk("rd_data", 32'(read_prt_entry), 32'(exp_q.pop_front()));
            end
        end
    end

    // One clock of stimulus, driven and checked at the falling edge.
    task automatic step(input bit sw, input bit w, input logic [7:0] d, input bit fin,
                        input bit inv, input int islot, input bit sr, input int sslot,
                        input bit rd);
        int ff, pre_ws;
        bit r_sw, r_w, r_fin, r_sr, r_rd, pre_wr, lastb;
        logic [8:0] e;
        EN_start_writing_prt_entry   = sw;
        EN_write_prt_entry           = w;
        write_prt_entry_data         = d;
        EN_finish_writing_prt_entry  = fin;
        EN_invalidate_prt_entry      = inv;
        invalidate_prt_entry_slot    = 4'(islot);
        EN_start_reading_prt_entry   = sr;
        start_reading_prt_entry_slot = 4'(sslot);
        EN_read_prt_entry            = rd;
        #1;
        ff    = m_first_free();
        r_sw  = (ff >= 0) && !m_wr;
        r_w   = m_wr && (m_wcnt < DEPTH);
        r_fin = m_wr;
        r_sr  = !m_rd;
        r_rd  = m_rd;
        chk("rdy_start_w", 32'(RDY_start_writing_prt_entry), 32'(r_sw));
        chk("rdy_write", 32'(RDY_write_prt_entry), 32'(r_w));
        chk("rdy_finish", 32'(RDY_finish_writing_prt_entry), 32'(r_fin));
        chk("rdy_start_r", 32'(RDY_start_reading_prt_entry), 32'(r_sr));
        chk("rdy_read", 32'(RDY_read_prt_entry), 32'(r_rd));
        chk("slot_free", 32'(is_prt_slot_free), 32'(ff >= 0));
        @(posedge CLK);
        pre_wr = m_wr;
        pre_ws = m_wslot;
        if (rd && r_rd) begin
            if (m_rlen == 0) begin
                e = 9'h100;
                m_rd = 0;
            end else begin
                lastb = (m_rcnt == m_rlen - 1);
                e = {lastb, m_mem[m_rslot][m_rcnt]};
                m_rcnt++;
                if (lastb) m_rd = 0;
            end
            exp_q.push_back(e);
            m_out = e;
        end
        if (sr && r_sr && sslot < NS && m_valid[sslot]) begin
            m_rd = 1; m_rslot = sslot; m_rcnt = 0; m_rlen = m_len[sslot];
        end
        if (w && r_w) begin
            m_mem[m_wslot][m_wcnt] = d;
            m_wcnt++;
        end
        if (sw && r_sw) begin
            m_wr = 1; m_wslot = ff; m_wcnt = 0; m_alloc = ff;
        end
        if (fin && r_fin) begin
            m_valid[pre_ws] = 1;
            m_len[pre_ws]   = m_wcnt;
            m_wr            = 0;
        end
        if (inv && islot < NS && !(pre_wr && islot == pre_ws)) m_valid[islot] = 0;
        @(negedge CLK);
        EN_start_writing_prt_entry  = 0;
        EN_write_prt_entry          = 0;
        EN_finish_writing_prt_entry = 0;
        EN_invalidate_prt_entry     = 0;
        EN_start_reading_prt_entry  = 0;
        EN_read_prt_entry           = 0;
        chk("alloc_idx", 32'(start_writing_prt_entry), 32'(m_alloc));
    endtask

    task automatic alloc();             step(1, 0, 8'h00, 0, 0, 0, 0, 0, 0); endtask
    task automatic wr(input logic [7:0] d); step(0, 1, d, 0, 0, 0, 0, 0, 0); endtask
    task automatic fin();               step(0, 0, 8'h00, 1, 0, 0, 0, 0, 0); endtask
    task automatic inv(input int s);    step(0, 0, 8'h00, 0, 1, s, 0, 0, 0); endtask
    task automatic sread(input int s);  step(0, 0, 8'h00, 0, 0, 0, 1, s, 0); endtask
    task automatic rd();                step(0, 0, 8'h00, 0, 0, 0, 0, 0, 1); endtask

    task automatic write_pkt(input int n);
        alloc();
        for (int i = 0; i < n; i++) wr(8'(i));
        fin();
    endtask

    task automatic apply_reset();
        RST_N = 0;
        m_reset();
        repeat (2) @(negedge CLK);
        RST_N = 1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        EN_start_writing_prt_entry = 0; EN_write_prt_entry = 0; EN_finish_writing_prt_entry = 0;
        EN_invalidate_prt_entry = 0; EN_start_reading_prt_entry = 0; EN_read_prt_entry = 0;
        write_prt_entry_data = 0; invalidate_prt_entry_slot = 0; start_reading_prt_entry_slot = 0;
        @(negedge CLK);
        apply_reset();
        chk("rst_alloc", 32'(start_writing_prt_entry), 32'h0);
        chk("rst_rdout", 32'(read_prt_entry), 32'h0);
        chk("rst_free", 32'(is_prt_slot_free), 32'h1);
        chk("rst_rdy_inv", 32'(RDY_invalidate_prt_entry), 32'h1);
        chk("rst_rdy_free", 32'(RDY_is_prt_slot_free), 32'h1);

        // Basic write / read-back, then reads past the end are ignored.
        write_pkt(5);
        chk("s1_slot", 32'(start_writing_prt_entry), 32'h0);
        sread(0);
        repeat (5) rd();
        repeat (5) rd();
        chk("s1_hold", 32'(read_prt_entry), 32'h104);

        // Release and reallocate the same slot.
        inv(0);
        write_pkt(5);
        chk("s2_slot", 32'(start_writing_prt_entry), 32'h0);
        sread(0);
        repeat (5) rd();

        // Fill every slot in index order.
        inv(0);
        for (int i = 0; i < NS; i++) begin
            write_pkt(3);
            chk("fill_order", 32'(start_writing_prt_entry), 32'(i));
        end
        chk("full_free", 32'(is_prt_slot_free), 32'h0);
        alloc();
        chk("full_alloc", 32'(start_writing_prt_entry), 32'h9);

        // From full, free slot 0 and reuse it with 4 bytes.
        inv(0);
        write_pkt(4);
        chk("s4_slot", 32'(start_writing_prt_entry), 32'h0);
        sread(0);
        repeat (4) rd();

        // Invalidate during another slot's write; read start on the freed slot has no effect.
        inv(5);
        alloc();
        wr(8'hA0);
        inv(3);
        wr(8'hA1);
        sread(3);
        rd();
        inv(5);
        fin();
        write_pkt(2);
        chk("s5_refill", 32'(start_writing_prt_entry), 32'h3);
        // Invalidate and allocate together while full: allocation sees the pre-edge state.
        step(1, 0, 8'h00, 0, 1, 7, 0, 0, 0);
        alloc();
        chk("s5_alloc7", 32'(start_writing_prt_entry), 32'h7);
        fin();

        // Randomised traffic.
        for (int n = 0; n < 3000; n++) begin
            bit f, w;
            f = ($urandom_range(15, 0) == 0);
            w = !f && ($urandom_range(1, 0) == 1);
            step($urandom_range(3, 0) == 0, w, 8'($urandom), f,
                 $urandom_range(7, 0) == 0, int'($urandom_range(15, 0)),
                 $urandom_range(5, 0) == 0, int'($urandom_range(15, 0)),
                 $urandom_range(1, 0) == 1);
        end
        if (m_wr) fin();
        for (int n = 0; n < DEPTH + 2 && m_rd; n++) rd();
        for (int i = 0; i < NS; i++) inv(i);

        // Maximum-size packet; one byte beyond the slot is refused.
        alloc();
        for (int i = 0; i < DEPTH; i++) wr(8'($urandom));
        wr(8'h5A);
        fin();
        sread(0);
        for (int i = 0; i < DEPTH; i++) rd();

        // Zero-length packet, then reset in the middle of a read.
        write_pkt(0);
        chk("zero_slot", 32'(start_writing_prt_entry), 32'h1);
        sread(1);
        rd();
        chk("zero_out", 32'(read_prt_entry), 32'h100);
        write_pkt(3);
        sread(2);
        rd();
        #2;
        RST_N = 0;
        m_reset();
        #1;
        chk("mid_rst_rdout", 32'(read_prt_entry), 32'h0);
        chk("mid_rst_free", 32'(is_prt_slot_free), 32'h1);
        chk("mid_rst_alloc", 32'(start_writing_prt_entry), 32'h0);
        chk("mid_rst_rdy_rd", 32'(RDY_read_prt_entry), 32'h0);
        @(negedge CLK);
        RST_N = 1;
        sread(2);
        rd();
        chk("post_rst_rdout", 32'(read_prt_entry), 32'h0);

        repeat (2) @(negedge CLK);
        chk("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
